// File: rtl/fp9_lane_unpacker.sv
// fp9_lane_unpacker
//   Streaming front-end for the tensor datapath. Takes one packed operand word
//   per handshake (FP4 E2M1, FP8 E4M3, FP8 E5M2 or FP16), converts every element
//   to FP9 (1 sign / 5 exponent / 3 mantissa, bias 15) and emits LANES FP9
//   elements per output beat toward the FP9 multiplier array.
//
//   Optional feature: define FP9_STATUS_FLAGS_EN to add sticky status flags.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   in_valid_i       input word valid
//   in_ready_o       block can accept a word
//   in_fmt_i         00 FP4, 01 FP8E4M3, 10 FP8E5M2, 11 FP16
//   in_data_i        packed elements, element k at bits [k*w +: w]
//   out_valid_o      output beat valid
//   out_ready_i      consumer accepts beat
//   out_data_o       lane i at bits [9i +: 9]
//   out_mask_o       1 = lane carries a real element
//   out_last_o       final beat of the current word
//   flag_clr_i       (FP9_STATUS_FLAGS_EN) clear sticky flags
//   flags_o          (FP9_STATUS_FLAGS_EN) {invalid, overflow, underflow}
//   state_o          debug view of the FSM, 0 IDLE, 1 DRAIN
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and a presented beat holds its
// data, mask and last until it is transferred.
module fp9_lane_unpacker #(
    parameter int BUS_W = 64,
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [1:0]         in_fmt_i,
    input  logic [BUS_W-1:0]   in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [9*LANES-1:0] out_data_o,
    output logic [LANES-1:0]   out_mask_o,
    output logic               out_last_o,
`ifdef FP9_STATUS_FLAGS_EN
    input  logic               flag_clr_i,
    output logic [2:0]         flags_o,
`endif
    output logic               state_o
);

    localparam int MAX_B = (BUS_W / 4 + LANES - 1) / LANES;
    localparam int CW    = (MAX_B > 1) ? $clog2(MAX_B) : 1;

    typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [BUS_W-1:0]     data_q;
    logic [1:0]           fmt_q;
    logic [CW-1:0]        beat_q;
    logic [9*LANES-1:0]   out_data_q;
    logic [LANES-1:0]     out_mask_q;
    logic                 out_last_q;

    logic                 accept, advance, load;
    logic [BUS_W-1:0]     src_data;
    logic [1:0]           src_fmt;
    int                   src_beat;
    logic [15:0]          raw;
    logic [9*LANES-1:0]   nxt_data;
    logic [LANES-1:0]     nxt_mask;
    logic                 nxt_last;

    function automatic int elem_w(input logic [1:0] fmt);
        case (fmt)
            2'b00:   return 4;
            2'b11:   return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int elems_for(input logic [1:0] fmt);
        return BUS_W / elem_w(fmt);
    endfunction

    function automatic int beats_for(input logic [1:0] fmt);
        return (elems_for(fmt) + LANES - 1) / LANES;
    endfunction

    function automatic logic [8:0] cvt(input logic [1:0] fmt, input logic [15:0] r);
        logic [7:0] sum;
        logic       rnd;
        logic [8:0] res;
        sum = '0;
        rnd = 1'b0;
        res = '0;
        case (fmt)
            2'b00: begin
                if (r[2:1] != 2'b00)  res = {r[3], 5'(r[2:1]) + 5'd14, r[0], 2'b00};
                else if (r[0])        res = {r[3], 5'd14, 3'd0};
                else                  res = {r[3], 8'd0};
            end
            2'b01: begin
                // E4M3 subnormals are exact FP9 normals: locate the leading one.
                if (r[6:0] == 7'h7F)       res = {r[7], 8'hFC};
                else if (r[6:3] != 4'd0)   res = {r[7], 5'(r[6:3]) + 5'd8, r[2:0]};
                else if (r[2])             res = {r[7], 5'd8, r[1:0], 1'b0};
                else if (r[1])             res = {r[7], 5'd7, r[0], 2'b00};
                else if (r[0])             res = {r[7], 5'd6, 3'd0};
                else                       res = {r[7], 8'd0};
            end
            2'b10: begin
                if (r[6:2] == 5'h1F && r[1:0] != 2'b00) res = {r[7], 8'hFC};
                else                                    res = {r[7:0], 1'b0};
            end
            default: begin
                if (r[14:10] == 5'h1F) begin
                    res = (r[9:0] == 10'd0) ? {r[15], 8'hF8} : {r[15], 8'hFC};
                end else if (r[14:10] == 5'h00) begin
                    res = {r[15], 8'd0};
                end else begin
                    // RNE on {exp,man}: a mantissa carry ripples into the exponent
                    // and from exp 30 lands exactly on the inf encoding.
                    rnd = r[6] & ((|r[5:0]) | r[7]);
                    sum = {r[14:10], r[9:7]} + {7'd0, rnd};
                    res = {r[15], sum};
                end
            end
        endcase
        return res;
    endfunction

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_d = DRAIN;
            end
            default: begin
                in_ready_o = out_last_q & out_ready_i;
                if (out_last_q && out_ready_i && !in_valid_i) state_d = IDLE;
            end
        endcase
    end

    assign accept  = in_valid_i & in_ready_o;
    assign advance = (state_q == DRAIN) & out_ready_i;
    assign load    = accept | (advance & ~out_last_q);

    // Next beat is built from the incoming word on accept, otherwise from the
    // latched word at the following beat index.
    always_comb begin
        src_data = data_q;
        src_fmt  = fmt_q;
        src_beat = int'(beat_q) + 1;
        if (accept) begin
            src_data = in_data_i;
            src_fmt  = in_fmt_i;
            src_beat = 0;
        end
        raw      = '0;
        nxt_data = '0;
        nxt_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            if (src_beat * LANES + i < elems_for(src_fmt)) begin
                raw = 16'(src_data >> ((src_beat * LANES + i) * elem_w(src_fmt)));
                nxt_data[9*i +: 9] = cvt(src_fmt, raw);
                nxt_mask[i]        = 1'b1;
            end
        end
        nxt_last = (src_beat == beats_for(src_fmt) - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            fmt_q      <= '0;
            beat_q     <= '0;
            out_data_q <= '0;
            out_mask_q <= '0;
            out_last_q <= 1'b0;
        end else if (load) begin
            if (accept) begin
                data_q <= in_data_i;
                fmt_q  <= in_fmt_i;
                beat_q <= '0;
            end else begin
                beat_q <= beat_q + CW'(1);
            end
            out_data_q <= nxt_data;
            out_mask_q <= nxt_mask;
            out_last_q <= nxt_last;
        end
    end

    assign out_valid_o = (state_q == DRAIN);
    assign out_data_o  = out_data_q;
    assign out_mask_o  = out_mask_q;
    assign out_last_o  = out_last_q;
    assign state_o     = (state_q == DRAIN);

`ifdef FP9_STATUS_FLAGS_EN
    // {invalid, overflow, underflow} for one element. Overflow is a finite
    // FP16 value rounding up to inf; underflow is a nonzero FP16 subnormal
    // flushed to zero.
    function automatic logic [2:0] flag_of(input logic [1:0] fmt, input logic [15:0] r);
        logic [2:0] f;
        f = 3'b000;
        case (fmt)
            2'b01:   f[2] = (r[6:0] == 7'h7F);
            2'b10:   f[2] = (r[6:2] == 5'h1F) && (r[1:0] != 2'b00);
            2'b11: begin
                f[2] = (r[14:10] == 5'h1F) && (r[9:0] != 10'd0);
                f[1] = (r[14:10] == 5'h1E) && (r[9:6] == 4'hF);
                f[0] = (r[14:10] == 5'h00) && (r[9:0] != 10'd0);
            end
            default: f = 3'b000;
        endcase
        return f;
    endfunction

    logic [2:0] flags_q;
    logic [2:0] nxt_flags;
    logic [15:0] fraw;

    always_comb begin
        nxt_flags = '0;
        fraw      = '0;
        for (int i = 0; i < LANES; i++) begin
            if (src_beat * LANES + i < elems_for(src_fmt)) begin
                fraw      = 16'(src_data >> ((src_beat * LANES + i) * elem_w(src_fmt)));
                nxt_flags = nxt_flags | flag_of(src_fmt, fraw);
            end
        end
    end

    // A set in the same cycle as a clear survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else        flags_q <= (flag_clr_i ? 3'b000 : flags_q) | (load ? nxt_flags : 3'b000);
    end

    assign flags_o = flags_q;
`endif

endmodule

// File: tb/tb_fp9_lane_unpacker.sv
// Directed bench for fp9_lane_unpacker: a 64-bit/4-lane instance for the main
// function and a 48-bit instance for the partial-beat case.
module tb_fp9_lane_unpacker;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_last, state_dbg;
    logic [1:0]  in_fmt;
    logic [63:0] in_data;
    logic [35:0] out_data;
    logic [3:0]  out_mask;

    logic        in_valid48, in_ready48, out_valid48, out_ready48, out_last48, state48;
    logic [1:0]  in_fmt48;
    logic [47:0] in_data48;
    logic [35:0] out_data48;
    logic [3:0]  out_mask48;

`ifdef FP9_STATUS_FLAGS_EN
    logic        flag_clr, flag_clr48;
    logic [2:0]  flags, flags48;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] fp4_tab [16];

    fp9_lane_unpacker #(.BUS_W(64), .LANES(4)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_fmt_i    (in_fmt),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_mask_o  (out_mask),
        .out_last_o  (out_last),
`ifdef FP9_STATUS_FLAGS_EN
        .flag_clr_i  (flag_clr),
        .flags_o     (flags),
`endif
        .state_o     (state_dbg)
    );

    fp9_lane_unpacker #(.BUS_W(48), .LANES(4)) u_dut48 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid48),
        .in_ready_o  (in_ready48),
        .in_fmt_i    (in_fmt48),
        .in_data_i   (in_data48),
        .out_valid_o (out_valid48),
        .out_ready_i (out_ready48),
        .out_data_o  (out_data48),
        .out_mask_o  (out_mask48),
        .out_last_o  (out_last48),
`ifdef FP9_STATUS_FLAGS_EN
        .flag_clr_i  (flag_clr48),
        .flags_o     (flags48),
`endif
        .state_o     (state48)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] pk(input logic [8:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk_beat(input string tag, input logic [35:0] d, input logic [3:0] m,
                            input logic l);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"},  64'(out_data),  64'(d));
        chk({tag, "_mask"},  64'(out_mask),  64'(m));
        chk({tag, "_last"},  64'(out_last),  64'(l));
    endtask

    // Present a word and hold it until the edge where it is accepted; returns
    // #1 after that edge.
    task automatic send(input logic [1:0] fmt, input logic [63:0] data);
        int cnt;
        cnt      = 0;
        in_valid = 1'b1;
        in_fmt   = fmt;
        in_data  = data;
        while (!in_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        fp4_tab = '{9'h000, 9'h070, 9'h078, 9'h07C, 9'h080, 9'h084, 9'h088, 9'h08C,
                    9'h100, 9'h170, 9'h178, 9'h17C, 9'h180, 9'h184, 9'h188, 9'h18C};
        rst_n = 1'b0;
        in_valid = 1'b0; in_fmt = 2'b00; in_data = '0; out_ready = 1'b0;
        in_valid48 = 1'b0; in_fmt48 = 2'b00; in_data48 = '0; out_ready48 = 1'b1;
`ifdef FP9_STATUS_FLAGS_EN
        flag_clr = 1'b0; flag_clr48 = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_mask",  64'(out_mask),  64'd0);
        chk("rst_out_last",  64'(out_last),  64'd0);
        chk("rst_state",     64'(state_dbg), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // FP16 specials and rounding to inf, single beat
        out_ready = 1'b1;
        send(2'b11, 64'h7BFF_FC00_0001_3C00);
        chk_beat("fp16a", pk(9'h078, 9'h000, 9'h1F8, 9'h0F8), 4'hF, 1'b1);
        chk("fp16a_state", 64'(state_dbg), 64'd1);
        @(posedge clk); #1;
        chk("fp16a_idle_valid", 64'(out_valid), 64'd0);
        chk("fp16a_idle_ready", 64'(in_ready),  64'd1);

        // FP16 round-to-nearest-even cases
        send(2'b11, 64'hBBFF_3C41_3CC0_3C40);
        chk_beat("fp16b", pk(9'h078, 9'h07A, 9'h079, 9'h178), 4'hF, 1'b1);
        @(posedge clk); #1;

        // FP4 all 6.0: four identical beats, last only on beat 3
        send(2'b00, 64'h7777_7777_7777_7777);
        for (int b = 0; b < 4; b++) begin
            chk_beat($sformatf("fp4six_b%0d", b), pk(9'h08C, 9'h08C, 9'h08C, 9'h08C), 4'hF,
                     (b == 3));
            @(posedge clk); #1;
        end
        chk("fp4six_end_valid", 64'(out_valid), 64'd0);

        // E4M3: NaN, subnormals, signed zero
        send(2'b01, 64'h03_06_08_80_00_38_01_7F);
        chk_beat("e4m3_b0", pk(9'h0FC, 9'h030, 9'h078, 9'h000), 4'hF, 1'b0);
        @(posedge clk); #1;
        chk_beat("e4m3_b1", pk(9'h100, 9'h048, 9'h044, 9'h03C), 4'hF, 1'b1);
        @(posedge clk); #1;

        // E5M2: inf, NaN, subnormal
        send(2'b10, 64'h80_7D_7B_00_01_FF_7C_3C);
        chk_beat("e5m2_b0", pk(9'h078, 9'h0F8, 9'h1FC, 9'h002), 4'hF, 1'b0);
        @(posedge clk); #1;
        chk_beat("e5m2_b1", pk(9'h000, 9'h0F6, 9'h0FC, 9'h100), 4'hF, 1'b1);
        @(posedge clk); #1;

        // Stall for 5 cycles on beat 1 of an FP4 word
        out_ready = 1'b0;
        send(2'b00, 64'hFEDC_BA98_7654_3210);
        chk_beat("stall_b0", pk(fp4_tab[0], fp4_tab[1], fp4_tab[2], fp4_tab[3]), 4'hF, 1'b0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk_beat($sformatf("stall_hold%0d", c),
                     pk(fp4_tab[4], fp4_tab[5], fp4_tab[6], fp4_tab[7]), 4'hF, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        chk_beat("stall_b1", pk(fp4_tab[4], fp4_tab[5], fp4_tab[6], fp4_tab[7]), 4'hF, 1'b0);
        @(posedge clk); #1;
        chk_beat("stall_b2", pk(fp4_tab[8], fp4_tab[9], fp4_tab[10], fp4_tab[11]), 4'hF, 1'b0);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_b2_hold_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_beat("stall_b3", pk(fp4_tab[12], fp4_tab[13], fp4_tab[14], fp4_tab[15]), 4'hF, 1'b1);

        // Back-to-back: next word offered on the final beat, no bubble
        in_valid = 1'b1; in_fmt = 2'b11; in_data = 64'h7BFF_FC00_0001_3C00;
        #0;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk_beat("b2b_w1", pk(9'h078, 9'h000, 9'h1F8, 9'h0F8), 4'hF, 1'b1);
        in_data = 64'h4000_C000_3C00_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_beat("b2b_w2", pk(9'h000, 9'h078, 9'h180, 9'h080), 4'hF, 1'b1);
        @(posedge clk); #1;
        chk("b2b_end_valid", 64'(out_valid), 64'd0);

        // Reset during beat 1 discards the word; next word restarts at beat 0
        send(2'b00, 64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;
        chk_beat("rstmid_b1", pk(fp4_tab[11], fp4_tab[10], fp4_tab[9], fp4_tab[8]), 4'hF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", 64'(out_valid), 64'd0);
        chk("rstmid_ready", 64'(in_ready),  64'd1);
        chk("rstmid_mask",  64'(out_mask),  64'd0);
        chk("rstmid_last",  64'(out_last),  64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_idle_valid", 64'(out_valid), 64'd0);
        send(2'b00, 64'h0123_4567_89AB_CDEF);
        chk_beat("rstmid_restart", pk(fp4_tab[15], fp4_tab[14], fp4_tab[13], fp4_tab[12]),
                 4'hF, 1'b0);
        for (int b = 1; b < 4; b++) begin
            @(posedge clk); #1;
        end
        chk("rstmid_restart_last", 64'(out_last), 64'd1);
        @(posedge clk); #1;

        // 48-bit bus, FP16: three real lanes, lane 3 empty
        in_valid48 = 1'b1; in_fmt48 = 2'b11; in_data48 = 48'h4000_C000_3C00;
        #0;
        chk("w48_in_ready", 64'(in_ready48), 64'd1);
        @(posedge clk); #1;
        in_valid48 = 1'b0;
        chk("w48_valid", 64'(out_valid48), 64'd1);
        chk("w48_data",  64'(out_data48),  64'(pk(9'h078, 9'h180, 9'h080, 9'h000)));
        chk("w48_mask",  64'(out_mask48),  64'h7);
        chk("w48_last",  64'(out_last48),  64'd1);
        @(posedge clk); #1;
        chk("w48_end_valid", 64'(out_valid48), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
